hyperspectral_hw_wrapped_band_accum: RTL

HYPERSPECTRAL_HW_WRAPPED_BAND_ACCUM -- requirements
Module: hyperspectral_hw_wrapped_band_accum

---
 rtl/hyperspectral_hw_wrapped_pkg.sv | 7 +
 rtl/hyperspectral_hw_wrapped_band_accum.sv | 107 ++++++++++
 2 files changed

// File: rtl/hyperspectral_hw_wrapped_pkg.sv
// hyperspectral_hw_wrapped_pkg: shared state encoding and saturation limits for the band accumulator.
package hyperspectral_hw_wrapped_pkg;
   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
   localparam int ACC_W_DEF = 32;
   localparam logic signed [ACC_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic signed [ACC_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};
endpackage

// File: rtl/hyperspectral_hw_wrapped_band_accum.sv
// hyperspectral_hw_wrapped_band_accum: saturating per-pixel sum of signed band products,
// one result per pixel held until the downstream handshake completes.
module hyperspectral_hw_wrapped_band_accum
   import hyperspectral_hw_wrapped_pkg::*;
#(
   parameter int PROD_W    = 19,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int NUM_BANDS = 224
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [PROD_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_data,
   output logic                    out_sat,
   output logic                    out_err,
   output logic [15:0]             pix_cnt
);
   localparam int BW = $clog2(NUM_BANDS);
   localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d, out_data_q, out_data_d;
   logic [BW-1:0]            band_cnt_q, band_cnt_d;
   logic [15:0]              pix_cnt_q, pix_cnt_d;
   logic                     sat_q, sat_d, out_valid_q, out_valid_d;
   logic                     out_sat_q, out_sat_d, out_err_q, out_err_d;
   logic                     accept, first, at_last, term, ovf, sat_new;
   logic [ACC_W:0]           prod_x, sum;
   logic [ACC_W-1:0]         clamped;

   always_comb begin
      accept  = in_valid & (state_q == ACCUM);
      first   = band_cnt_q == '0;
      at_last = band_cnt_q == LAST_BAND;
      term    = accept & (in_last | at_last);
      prod_x  = {{(ACC_W+1-PROD_W){in_data[PROD_W-1]}}, in_data};
      // first beat loads fresh so nothing from the previous pixel leaks in
      sum     = first ? prod_x : {acc_q[ACC_W-1], acc_q} + prod_x;
      ovf     = sum[ACC_W] ^ sum[ACC_W-1];
      clamped = ovf ? (sum[ACC_W] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];
      sat_new = (first ? 1'b0 : sat_q) | ovf;
      state_d     = state_q;
      acc_d       = acc_q;
      band_cnt_d  = band_cnt_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_err_d   = out_err_q;
      pix_cnt_d   = pix_cnt_q;
      if (accept) begin
         acc_d      = clamped;
         sat_d      = sat_new;
         band_cnt_d = term ? '0 : band_cnt_q + 1'b1;
      end
      if (term) begin
         out_data_d  = clamped;
         out_sat_d   = sat_new;
         out_err_d   = in_last ^ at_last;
         out_valid_d = 1'b1;
         pix_cnt_d   = pix_cnt_q + 16'd1;
         state_d     = HOLD;
      end
      if (state_q == HOLD && out_ready) begin
         out_valid_d = 1'b0;
         state_d     = ACCUM;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         band_cnt_q  <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_err_q   <= 1'b0;
         pix_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         band_cnt_q  <= band_cnt_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_err_q   <= out_err_d;
         pix_cnt_q   <= pix_cnt_d;
      end
   end

   assign in_ready  = state_q == ACCUM;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_err   = out_err_q;
   assign pix_cnt   = pix_cnt_q;
endmodule
